// File: rtl/flags_pkg.sv
// Shared constants for the status-flag register: flag bit positions, W_RF
// write-mode encodings with their masks, and branch condition codes.
package flags_pkg;

  localparam int FLAG_Z     = 0;
  localparam int FLAG_C     = 1;
  localparam int FLAG_S     = 2;
  localparam int FLAG_O     = 3;
  localparam int ARCH_FLAGS = 4;

  localparam logic [2:0] WRF_NONE = 3'd0;
  localparam logic [2:0] WRF_Z    = 3'd1;
  localparam logic [2:0] WRF_SZ   = 3'd2;
  localparam logic [2:0] WRF_SCZ  = 3'd3;
  localparam logic [2:0] WRF_OSCZ = 3'd4;
  localparam logic [2:0] WRF_ALL  = 3'd5;

  localparam logic [3:0] COND_AL = 4'd0;
  localparam logic [3:0] COND_Z  = 4'd1;
  localparam logic [3:0] COND_NZ = 4'd2;
  localparam logic [3:0] COND_C  = 4'd3;
  localparam logic [3:0] COND_NC = 4'd4;
  localparam logic [3:0] COND_S  = 4'd5;
  localparam logic [3:0] COND_NS = 4'd6;
  localparam logic [3:0] COND_O  = 4'd7;
  localparam logic [3:0] COND_NO = 4'd8;
  localparam logic [3:0] COND_GE = 4'd9;
  localparam logic [3:0] COND_LT = 4'd10;
  localparam logic [3:0] COND_GT = 4'd11;
  localparam logic [3:0] COND_LE = 4'd12;

  // Mask over the four architectural flags; user flags are only reached
  // through WRF_ALL, see mode_all().
  function automatic logic [3:0] mode_to_mask(input logic [2:0] mode);
    logic [3:0] m;
    m = 4'b0000;
    case (mode)
      WRF_Z:            m[FLAG_Z] = 1'b1;
      WRF_SZ:           begin m[FLAG_Z] = 1'b1; m[FLAG_S] = 1'b1; end
      WRF_SCZ:          begin m[FLAG_Z] = 1'b1; m[FLAG_C] = 1'b1; m[FLAG_S] = 1'b1; end
      WRF_OSCZ, WRF_ALL: m = 4'b1111;
      default:          m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic mode_all(input logic [2:0] mode);
    return mode == WRF_ALL;
  endfunction

  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, s, o, r;
    z = f[FLAG_Z];
    c = f[FLAG_C];
    s = f[FLAG_S];
    o = f[FLAG_O];
    case (cond)
      COND_AL: r = 1'b1;
      COND_Z:  r = z;
      COND_NZ: r = !z;
      COND_C:  r = c;
      COND_NC: r = !c;
      COND_S:  r = s;
      COND_NS: r = !s;
      COND_O:  r = o;
      COND_NO: r = !o;
      COND_GE: r = (s == o);
      COND_LT: r = (s != o);
      COND_GT: r = !z && (s == o);
      COND_LE: r = z || (s != o);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flags_lifo.sv
// Save/restore LIFO for flag words: DEPTH entries plus a registered count,
// empty and full. Callers only assert push when not full and pop when not empty.
module flags_lifo #(
  parameter int NFLAGS = 4,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              xchg,
  input  logic [NFLAGS-1:0] wr_data,
  output logic [NFLAGS-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NFLAGS-1:0] mem [DEPTH];
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     wr_idx;
  logic [CW-1:0]     count_nxt;

  assign top_idx = (count == '0) ? '0 : AW'(count - CW'(1));
  assign wr_idx  = AW'(count);
  assign rd_data = mem[top_idx];

  always_comb begin
    count_nxt = count;
    if (push && !full)
      count_nxt = count + CW'(1);
    else if (pop && !empty)
      count_nxt = count - CW'(1);
  end

  // Entry contents are deliberately left out of reset; only the count matters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push && !full)
        mem[wr_idx] <= wr_data;
      else if (xchg && !empty)
        mem[top_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/register_flags_stack.sv
// Registered status-flag register with W_RF write masking, save/restore LIFO
// and sticky stack error. Defining FLAGS_COND_EN adds the cond/cond_true decode.
module register_flags_stack
  import flags_pkg::*;
#(
  parameter int NFLAGS = 4,
  parameter int DEPTH  = 4,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NFLAGS-1:0] in_flags,
  input  logic [2:0]        W_RF,
  input  logic              push,
  input  logic              pop,
  input  logic              err_clr,
  output logic [NFLAGS-1:0] out_flags,
  output logic [CW-1:0]     stk_count,
  output logic              stk_empty,
  output logic              stk_full,
  output logic              stk_err
`ifdef FLAGS_COND_EN
  ,
  input  logic [3:0]        cond,
  output logic              cond_true
`endif
);

  if (NFLAGS < ARCH_FLAGS) begin : g_bad_nflags
    $error("NFLAGS must be at least 4");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("DEPTH must be at least 1");
  end

  logic [NFLAGS-1:0] mask;
  logic [NFLAGS-1:0] wr_flags;
  logic [NFLAGS-1:0] top_flags;
  logic [NFLAGS-1:0] flags_nxt;
  logic              lifo_push;
  logic              lifo_pop;
  logic              lifo_xchg;
  logic              overflow;
  logic              underflow;

  assign mask     = mode_all(W_RF) ? '1 : NFLAGS'(mode_to_mask(W_RF));
  assign wr_flags = (out_flags & ~mask) | (in_flags & mask);

  // push+pop on an empty stack degrades to a plain push; on a non-empty
  // stack it swaps top and flags, so it can never overflow.
  assign lifo_xchg = push && pop && !stk_empty;
  assign lifo_push = push && (!pop || stk_empty) && !stk_full;
  assign lifo_pop  = pop && !push && !stk_empty;
  assign overflow  = push && !pop && stk_full;
  assign underflow = pop && !push && stk_empty;

  always_comb begin
    flags_nxt = wr_flags;
    if (lifo_pop || lifo_xchg)
      flags_nxt = top_flags;
  end

  flags_lifo #(
    .NFLAGS (NFLAGS),
    .DEPTH  (DEPTH),
    .CW     (CW)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push    (lifo_push),
    .pop     (lifo_pop),
    .xchg    (lifo_xchg),
    .wr_data (out_flags),
    .rd_data (top_flags),
    .count   (stk_count),
    .empty   (stk_empty),
    .full    (stk_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags <= '0;
      stk_err   <= 1'b0;
    end else begin
      out_flags <= flags_nxt;
      if (overflow || underflow)
        stk_err <= 1'b1;
      else if (err_clr)
        stk_err <= 1'b0;
    end
  end

`ifdef FLAGS_COND_EN
  assign cond_true = eval_cond(cond, out_flags[ARCH_FLAGS-1:0]);
`endif

endmodule

// File: tb/tb_register_flags_stack.sv
// Self-checking bench for register_flags_stack: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_register_flags_stack;

  localparam int NF = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          rst;
  logic [NF-1:0] in_flags;
  logic [2:0]    w_rf;
  logic          push;
  logic          pop;
  logic          err_clr;
  logic [NF-1:0] out_flags;
  logic [CW-1:0] stk_count;
  logic          stk_empty;
  logic          stk_full;
  logic          stk_err;
  logic [3:0]    cond;
  logic          cond_true;

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [NF-1:0] m_flags;
  logic [NF-1:0] m_q[$];
  logic          m_err;

  register_flags_stack #(.NFLAGS(NF), .DEPTH(D), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flags  (in_flags),
    .W_RF      (w_rf),
    .push      (push),
    .pop       (pop),
    .err_clr   (err_clr),
    .out_flags (out_flags),
    .stk_count (stk_count),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .stk_err   (stk_err)
`ifdef FLAGS_COND_EN
    ,
    .cond      (cond),
    .cond_true (cond_true)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NF-1:0] model_mask(input logic [2:0] w);
    case (w)
      3'd1:    return NF'(4'b0001);
      3'd2:    return NF'(4'b0101);
      3'd3:    return NF'(4'b0111);
      3'd4:    return NF'(4'b1111);
      3'd5:    return '1;
      default: return '0;
    endcase
  endfunction

  task automatic model_step();
    logic [NF-1:0] wf;
    logic [NF-1:0] tmp;
    logic          e;
    if (rst) begin
      m_flags = '0;
      m_q     = {};
      m_err   = 1'b0;
    end else begin
      e  = 1'b0;
      wf = (m_flags & ~model_mask(w_rf)) | (in_flags & model_mask(w_rf));
      if (push && pop && m_q.size() > 0) begin
        tmp = m_q[m_q.size()-1];
        m_q[m_q.size()-1] = m_flags;
        m_flags = tmp;
      end else if (pop && !push) begin
        if (m_q.size() > 0) m_flags = m_q.pop_back();
        else begin m_flags = wf; e = 1'b1; end
      end else if (push) begin
        if (m_q.size() < D) m_q.push_back(m_flags);
        else e = 1'b1;
        m_flags = wf;
      end else begin
        m_flags = wf;
      end
      if (e) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic drive(input logic [NF-1:0] f, input logic [2:0] w,
                       input logic p, input logic po, input logic ec, input logic r);
    in_flags = f;
    w_rf     = w;
    push     = p;
    pop      = po;
    err_clr  = ec;
    rst      = r;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(4'b1111, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(4'b1111, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1);
    tests_run++;
    if (out_flags !== 4'b0000 || stk_count !== 3'd0 || stk_empty !== 1'b1 ||
        stk_full !== 1'b0 || stk_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: flags=%b count=%0d empty=%b full=%b err=%b, expected 0000/0/1/0/0",
               out_flags, stk_count, stk_empty, stk_full, stk_err);
    end
  endtask

  task automatic test_write_modes();
    drive(4'b1111, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (out_flags !== 4'b0101) begin
      tests_failed++;
      $display("FAIL wrf_sz: got %b expected 0101", out_flags);
    end
    drive(4'b0000, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (out_flags !== 4'b0101) begin
      tests_failed++;
      $display("FAIL wrf_reserved: got %b expected 0101", out_flags);
    end
    drive(4'b1010, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (out_flags !== 4'b0010) begin
      tests_failed++;
      $display("FAIL wrf_scz: got %b expected 0010", out_flags);
    end
  endtask

  task automatic test_push_pop();
    drive(4'b1010, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'b0001, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (out_flags !== 4'b0001 || stk_count !== 3'd1 || stk_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL push: flags=%b count=%0d empty=%b expected 0001/1/0", out_flags, stk_count, stk_empty);
    end
    drive(4'b1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (out_flags !== 4'b1010 || stk_count !== 3'd0 || stk_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL pop: flags=%b count=%0d empty=%b expected 1010/0/1", out_flags, stk_count, stk_empty);
    end
  endtask

  task automatic test_overflow();
    logic [NF-1:0] exp_q[$];
    exp_q = {4'b1010, 4'b0001, 4'b0010, 4'b0011};
    for (int i = 1; i <= 5; i++) drive(NF'(i), 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (stk_count !== 3'd4 || stk_full !== 1'b1 || stk_err !== 1'b1 || out_flags !== 4'b0101) begin
      tests_failed++;
      $display("FAIL overflow: count=%0d full=%b err=%b flags=%b expected 4/1/1/0101",
               stk_count, stk_full, stk_err, out_flags);
    end
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      tests_run++;
      if (out_flags !== exp_q[3-i] || stk_count !== CW'(3 - i) || stk_err !== 1'b1) begin
        tests_failed++;
        $display("FAIL lifo_order%0d: flags=%b count=%0d err=%b expected %b/%0d/1",
                 i, out_flags, stk_count, stk_err, exp_q[3-i], 3 - i);
      end
    end
    drive(4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (stk_err !== 1'b0 || stk_empty !== 1'b1 || stk_full !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clr: err=%b empty=%b full=%b expected 0/1/0", stk_err, stk_empty, stk_full);
    end
  endtask

  task automatic test_underflow();
    drive(4'b0001, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (out_flags !== 4'b1011 || stk_err !== 1'b1 || stk_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL underflow: flags=%b err=%b count=%0d expected 1011/1/0", out_flags, stk_err, stk_count);
    end
    // A new error in the same cycle as err_clr must keep the flag set.
    drive(4'b0000, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (stk_err !== 1'b1 || out_flags !== 4'b1011) begin
      tests_failed++;
      $display("FAIL err_wins: err=%b flags=%b expected 1/1011", stk_err, out_flags);
    end
    drive(4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_exchange();
    drive(4'b0011, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(4'b1100, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(4'b1111, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (out_flags !== 4'b0011 || stk_count !== 3'd1 || stk_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL exchange: flags=%b count=%0d err=%b expected 0011/1/0", out_flags, stk_count, stk_err);
    end
    drive(4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (out_flags !== 4'b1100 || stk_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL exchange_top: flags=%b count=%0d expected 1100/0", out_flags, stk_count);
    end
    drive(4'b0110, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (out_flags !== 4'b0110 || stk_count !== 3'd1 || stk_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL pushpop_empty: flags=%b count=%0d err=%b expected 0110/1/0", out_flags, stk_count, stk_err);
    end
  endtask

  task automatic test_cond();
`ifdef FLAGS_COND_EN
    logic [3:0] codes[3];
    logic       exp_r[3];
    codes = '{4'd10, 4'd11, 4'd14};
    exp_r = '{1'b1, 1'b0, 1'b0};
    drive(4'b0100, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cond = codes[i];
      #1;
      tests_run++;
      if (cond_true !== exp_r[i]) begin
        tests_failed++;
        $display("FAIL cond%0d: got %b expected %b", codes[i], cond_true, exp_r[i]);
      end
    end
`endif
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive(NF'($urandom_range(0, (1 << NF) - 1)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));
      tests_run++;
      if (out_flags !== m_flags || stk_count !== CW'(m_q.size()) ||
          stk_empty !== (m_q.size() == 0) || stk_full !== (m_q.size() == D) ||
          stk_err !== m_err) begin
        tests_failed++;
        $display("FAIL random cyc=%0d: flags=%b count=%0d empty=%b full=%b err=%b, expected %b/%0d/%b/%b/%b",
                 cyc, out_flags, stk_count, stk_empty, stk_full, stk_err,
                 m_flags, m_q.size(), (m_q.size() == 0), (m_q.size() == D), m_err);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_flags      = '0;
    m_err        = 1'b0;
    cond         = 4'd0;
    rst          = 1'b1;
    in_flags     = '0;
    w_rf         = 3'd0;
    push         = 1'b0;
    pop          = 1'b0;
    err_clr      = 1'b0;
    test_reset();
    test_write_modes();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_exchange();
    test_cond();
    drive('0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
